col_frame_loader: RTL



---
 rtl/col_frame_loader_pkg.sv | 24 ++
 rtl/col_frame_loader_dec.sv | 34 +++
 rtl/col_frame_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/col_frame_loader_pkg.sv
// Shared types and header layout for the column configuration loader.
// Imported by the loader top and its strobe decoder.
package col_frame_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  localparam int COL_MSB   = 31;
  localparam int COL_LSB   = 27;
  localparam int FRAME_MSB = 26;
  localparam int FRAME_LSB = 22;
  localparam int COL_W     = COL_MSB - COL_LSB + 1;
  localparam int FRAME_W   = FRAME_MSB - FRAME_LSB + 1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_frame_loader_dec.sv
// Registered one-hot FrameStrobe decoder.
// Indices outside the strobe range decode to all-zero.
module frame_onehot_dec #(
  parameter int N  = 20,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o
);

  logic [N-1:0] oh_d;
  logic [N-1:0] oh_q;

  always_comb begin
    oh_d = '0;
    for (int i = 0; i < N; i++) begin
      oh_d[i] = en_i && (32'(idx_i) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oh_q <= '0;
    end else begin
      oh_q <= oh_d;
    end
  end

  assign onehot_o = oh_q;

endmodule

// File: rtl/col_frame_loader.sv
// Column configuration loader: header + one word per row, then a
// one-cycle FrameStrobe pulse framed by a setup and a hold cycle.
module col_frame_loader
  import col_frame_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int ColId           = 0
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [31:0]                             s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    err_frame,
  output logic [15:0]                             frames_written
);

  localparam int RW = cnt_w(NumberOfRows);
  localparam int DW = NumberOfRows * FrameBitsPerRow;

  state_e               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [FRAME_W-1:0]   idx_q, idx_d;
  logic                 match_q, match_d;
  logic                 err_q, err_d;
  logic [15:0]          fw_q, fw_d;
  logic [DW-1:0]        data_q;

  logic                 accept;
  logic                 col_hit;
  logic                 idx_ok;
  logic                 last_row;
  logic                 strobe_en;
  logic                 row_we;
  logic [COL_W-1:0]     hdr_col;
  logic [FRAME_W-1:0]   hdr_idx;

  assign hdr_col  = s_data[COL_MSB:COL_LSB];
  assign hdr_idx  = s_data[FRAME_MSB:FRAME_LSB];
  assign col_hit  = (hdr_col == COL_W'(ColId));
  assign idx_ok   = (32'(hdr_idx) < MaxFramesPerCol);
  assign last_row = (row_q == RW'(NumberOfRows - 1));
  assign accept   = s_valid && s_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LOAD;
      S_LOAD: begin
        if (accept && last_row) begin
          state_d = match_q ? S_SETUP : S_IDLE;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    busy      = 1'b1;
    strobe_en = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        s_ready = 1'b1;
        busy    = 1'b0;
      end
      (state_q == S_LOAD):  s_ready   = 1'b1;
      (state_q == S_SETUP): strobe_en = 1'b1;
      default: ;
    endcase
  end

  assign row_we = (state_q == S_LOAD) && accept && match_q;

  always_comb begin
    row_d   = row_q;
    idx_d   = idx_q;
    match_d = match_q;
    err_d   = 1'b0;
    fw_d    = fw_q;
    if ((state_q == S_IDLE) && accept) begin
      row_d   = '0;
      idx_d   = hdr_idx;
      match_d = col_hit && idx_ok;
      err_d   = col_hit && !idx_ok;
    end else if ((state_q == S_LOAD) && accept) begin
      row_d = row_q + RW'(1);
    end
    // Count lands on the same edge the strobe register fires.
    if (strobe_en && (fw_q != 16'hFFFF)) begin
      fw_d = fw_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q   <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      fw_q    <= '0;
    end else begin
      row_q   <= row_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      err_q   <= err_d;
      fw_q    <= fw_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
    end else if (row_we) begin
      data_q[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
    end
  end

  frame_onehot_dec #(
    .N  (MaxFramesPerCol),
    .IW (FRAME_W)
  ) u_dec (
    .clk      (CLK),
    .rst      (RST),
    .idx_i    (idx_q),
    .en_i     (strobe_en),
    .onehot_o (FrameStrobe)
  );

  assign FrameData      = data_q;
  assign err_frame      = err_q;
  assign frames_written = fw_q;

endmodule
